// File: rtl/led_peripheral.sv
// Purpose : memory-mapped LED peripheral; data/toggle/blink-mask/blink-period registers driving board LEDs.
// Latency : a store updates its register on the strobe edge, leds one edge later; reads return one edge after the strobe.
// Backpressure: none; every strobe is accepted in its cycle and readValid is a single-cycle pulse.
//
// Ports:
//   clk, rst        - system clock; asynchronous active-high reset
//   ledWriteEnable  - store strobe (one cycle per store), register chosen by regSel
//   ledReadEnable   - load strobe, register chosen by regSel
//   regSel          - register offset (address bits [3:2]): 0 data, 1 toggle, 2 blink mask, 3 blink period
//   writeData       - store data; bits above the target register width are dropped
//   readData        - registered, zero-extended read value (holds between reads)
//   readValid       - one-cycle pulse marking readData valid
//   leds            - registered LED drive
//
// Build option: define LED_BLINK_EN to include the blink engine (BLINK_MASK, BLINK_PERIOD,
// prescaler, phase). Without it offsets 2/3 ignore writes and read as 0.
module led_peripheral #(
  parameter int LED_WIDTH    = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ledWriteEnable,
  input  logic                  ledReadEnable,
  input  logic [1:0]            regSel,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  output logic [LED_WIDTH-1:0]  leds
);

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_TOGGLE = 2'd1;
  localparam logic [1:0] SEL_MASK   = 2'd2;
  localparam logic [1:0] SEL_PERIOD = 2'd3;

  logic [LED_WIDTH-1:0]  r_led_data;
  logic [LED_WIDTH-1:0]  r_leds;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;

  logic [LED_WIDTH-1:0]  w_wr_led;
  logic [LED_WIDTH-1:0]  w_blink_term;
  logic [DATA_WIDTH-1:0] w_read_mux;
  logic                  w_unused_wdata;

  assign w_wr_led = writeData[LED_WIDTH-1:0];
  // Upper store bits are intentionally dropped in some builds.
  assign w_unused_wdata = &{1'b0, writeData};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led_data <= '0;
    end else if (ledWriteEnable) begin
      if (regSel == SEL_DATA)
        r_led_data <= w_wr_led;
      else if (regSel == SEL_TOGGLE)
        r_led_data <= r_led_data ^ w_wr_led;
    end
  end

`ifdef LED_BLINK_EN
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  logic [LED_WIDTH-1:0]    r_blink_mask;
  logic [PERIOD_WIDTH-1:0] r_blink_period;
  logic [PERIOD_WIDTH-1:0] r_prescaler;
  logic                    r_blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_mask <= '0;
    end else if (ledWriteEnable && regSel == SEL_MASK) begin
      r_blink_mask <= w_wr_led;
    end
  end

  // A period write restarts the engine from phase 0 on the same edge.
  // Comparing against period-1 (period is non-zero here) wraps before the
  // counter could overflow, even at the all-ones period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_period <= '0;
      r_prescaler    <= '0;
      r_blink_phase  <= 1'b0;
    end else if (ledWriteEnable && regSel == SEL_PERIOD) begin
      r_blink_period <= writeData[PERIOD_WIDTH-1:0];
      r_prescaler    <= '0;
      r_blink_phase  <= 1'b0;
    end else if (r_blink_period == '0) begin
      r_prescaler    <= '0;
      r_blink_phase  <= 1'b0;
    end else if (r_prescaler == r_blink_period - PERIOD_ONE) begin
      r_prescaler    <= '0;
      r_blink_phase  <= ~r_blink_phase;
    end else begin
      r_prescaler    <= r_prescaler + PERIOD_ONE;
    end
  end

  assign w_blink_term = r_blink_phase ? r_blink_mask : '0;

  always_comb begin
    w_read_mux = '0;
    case (regSel)
      SEL_DATA, SEL_TOGGLE: w_read_mux = DATA_WIDTH'(r_led_data);
      SEL_MASK:             w_read_mux = DATA_WIDTH'(r_blink_mask);
      SEL_PERIOD:           w_read_mux = DATA_WIDTH'(r_blink_period);
      default:              w_read_mux = '0;
    endcase
  end
`else
  assign w_blink_term = '0;

  always_comb begin
    w_read_mux = '0;
    if (regSel == SEL_DATA || regSel == SEL_TOGGLE)
      w_read_mux = DATA_WIDTH'(r_led_data);
  end
`endif

  // LEDs are driven from the registered state, so they lag any update by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_leds <= '0;
    else
      r_leds <= r_led_data ^ w_blink_term;
  end

  // The read mux sees pre-edge register values, so a same-cycle write is not visible to the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= ledReadEnable;
      if (ledReadEnable)
        r_read_data <= w_read_mux;
    end
  end

  assign leds      = r_leds;
  assign readData  = r_read_data;
  assign readValid = r_read_valid;

endmodule

// File: tb/tb_led_peripheral.sv
module tb_led_peripheral;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ledWriteEnable = 1'b0;
  logic        ledReadEnable  = 1'b0;
  logic [1:0]  regSel = 2'd0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        readValid;
  logic [15:0] leds;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  led_peripheral dut (
    .clk(clk), .rst(rst),
    .ledWriteEnable(ledWriteEnable), .ledReadEnable(ledReadEnable),
    .regSel(regSel), .writeData(writeData),
    .readData(readData), .readValid(readValid), .leds(leds)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus cycles elapsed since the last
  // period write; blink phase = floor(elapsed / period) mod 2.
  logic [15:0] m_led;
  logic [15:0] m_leds_exp;
  logic        m_rv_exp;
  logic [31:0] exp_q[$];
`ifdef LED_BLINK_EN
  logic [15:0]     m_mask;
  logic [31:0]     m_period;
  longint unsigned m_elapsed;

  function automatic logic [15:0] blink_term();
    if (m_period == 32'd0) return 16'h0;
    return (((m_elapsed / m_period) % 2) == 1) ? m_mask : 16'h0;
  endfunction
`else
  function automatic logic [15:0] blink_term();
    return 16'h0;
  endfunction
`endif

  function automatic logic [31:0] reg_value(input logic [1:0] sel);
    case (sel)
      2'd0, 2'd1: return {16'h0, m_led};
`ifdef LED_BLINK_EN
      2'd2:       return {16'h0, m_mask};
      2'd3:       return m_period;
`endif
      default:    return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_led      <= 16'h0;
      m_leds_exp <= 16'h0;
      m_rv_exp   <= 1'b0;
      exp_q.delete();
`ifdef LED_BLINK_EN
      m_mask     <= 16'h0;
      m_period   <= 32'h0;
      m_elapsed  <= 0;
`endif
    end else begin
      m_leds_exp <= m_led ^ blink_term();
      m_rv_exp   <= ledReadEnable;
      if (ledReadEnable) exp_q.push_back(reg_value(regSel));
`ifdef LED_BLINK_EN
      m_elapsed <= m_elapsed + 1;
`endif
      if (ledWriteEnable) begin
        case (regSel)
          2'd0: m_led <= writeData[15:0];
          2'd1: m_led <= m_led ^ writeData[15:0];
`ifdef LED_BLINK_EN
          2'd2: m_mask <= writeData[15:0];
          2'd3: begin m_period <= writeData; m_elapsed <= 0; end
`endif
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle, pops the scoreboard whenever readValid pulses.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("leds", {16'h0, leds}, {16'h0, m_leds_exp});
      check("readValid", {31'h0, readValid}, {31'h0, m_rv_exp});
      if (readValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL readData: got 0x%0h with no read outstanding at %0t", readData, $time);
        end else begin
          check("readData", readData, exp_q.pop_front());
        end
      end
    end
  end

  // One bus cycle: inputs held across a single rising edge, then released.
  task automatic cyc(input logic we, input logic re, input logic [1:0] sel, input logic [31:0] d);
    ledWriteEnable = we;
    ledReadEnable  = re;
    regSel         = sel;
    writeData      = d;
    @(posedge clk);
    #1;
    ledWriteEnable = 1'b0;
    ledReadEnable  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_leds", {16'h0, leds}, 32'h0);
    check("reset_readValid", {31'h0, readValid}, 32'h0);
    check("reset_readData", readData, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Data write, upper bits dropped; toggle; toggle-register read.
    cyc(1'b1, 1'b0, 2'd0, 32'h1234_A5A5);
    idle(1);
    check("led_data_write", {16'h0, leds}, 32'h0000_A5A5);
    cyc(1'b1, 1'b0, 2'd1, 32'h0000_00FF);
    idle(1);
    check("led_toggle_write", {16'h0, leds}, 32'h0000_A55A);
    cyc(1'b0, 1'b1, 2'd1, 32'h0);
    check("toggle_read_data", readData, 32'h0000_A55A);
    check("toggle_read_valid", {31'h0, readValid}, 32'h1);
    idle(1);
    check("toggle_read_pulse_end", {31'h0, readValid}, 32'h0);

    // Same-cycle read and write of LED_DATA returns the old value.
    cyc(1'b1, 1'b0, 2'd0, 32'h0000_0011);
    cyc(1'b1, 1'b1, 2'd0, 32'h0000_0022);
    check("rw_same_cycle_old", readData, 32'h0000_0011);
    cyc(1'b0, 1'b1, 2'd0, 32'h0);
    check("rw_same_cycle_new", readData, 32'h0000_0022);

    // Blink register writes; only take effect when the blink engine exists.
    cyc(1'b1, 1'b0, 2'd2, 32'h0000_FFFF);
    cyc(1'b1, 1'b0, 2'd3, 32'h0000_0001);
    cyc(1'b1, 1'b0, 2'd0, 32'h0000_5555);
    idle(5);
    cyc(1'b0, 1'b1, 2'd3, 32'h0);
`ifndef LED_BLINK_EN
    check("noblink_leds", {16'h0, leds}, 32'h0000_5555);
    check("noblink_period_read", readData, 32'h0);
    check("noblink_period_valid", {31'h0, readValid}, 32'h1);
`endif
    idle(2);

`ifdef LED_BLINK_EN
    // Period 4 blink on mask 0x000F, then re-period to 2 while in phase 1.
    cyc(1'b1, 1'b0, 2'd2, 32'h0000_000F);
    cyc(1'b1, 1'b0, 2'd0, 32'h0);
    cyc(1'b1, 1'b0, 2'd3, 32'd4);
    idle(4);
    check("blink_p4_low", {16'h0, leds}, 32'h0);
    idle(1);
    check("blink_p4_high", {16'h0, leds}, 32'h0000_000F);
    cyc(1'b1, 1'b0, 2'd3, 32'd2);
    idle(1);
    check("reperiod_cleared", {16'h0, leds}, 32'h0);
    idle(1);
    check("reperiod_hold", {16'h0, leds}, 32'h0);
    idle(1);
    check("reperiod_toggle", {16'h0, leds}, 32'h0000_000F);
    cyc(1'b1, 1'b0, 2'd3, 32'd0);
    idle(6);
    check("blink_disabled", {16'h0, leds}, 32'h0);
`endif

    // Randomized traffic checked by the monitor against the model.
    for (int i = 0; i < 400; i++) begin
      logic        we, re;
      logic [1:0]  sel;
      logic [31:0] d;
      we  = ($urandom_range(0, 3) == 0);
      re  = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      d   = $urandom;
      if (sel == 2'd3) d = $urandom_range(0, 6);
      cyc(we, re, sel, d);
    end
    idle(2);

    // Asynchronous reset mid-read: outputs clear without a clock edge.
    cyc(1'b1, 1'b0, 2'd0, 32'h0000_00FF);
    cyc(1'b0, 1'b1, 2'd0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_leds", {16'h0, leds}, 32'h0);
    check("async_reset_readValid", {31'h0, readValid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 2'd0, 32'h0);
    check("post_reset_read", readData, 32'h0);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
